// File: rtl/spi_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_mem_pkg
// Purpose  : Shared types and defaults for the SPI memory master. It holds the
//            default field widths, the frame layout and the master FSM state
//            encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package spi_mem_pkg;

  localparam int DEF_ADDR_W = 7;
  localparam int DEF_DATA_W = 8;
  localparam int FRAME_BITS = 1 + DEF_ADDR_W + DEF_DATA_W;

  // The frame is shifted out MSB first, so the fields leave in this order:
  // rw, addr, data.
  typedef struct packed {
    logic                  rw;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } spi_frame_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOW  = 3'd1,
    HIGH = 3'd2,
    HOLD = 3'd3,
    GAP  = 3'd4
  } spi_m_state_t;

endpackage
`default_nettype wire

// File: rtl/spi_master_mem_sclk_tick.sv
`default_nettype none
// ============================================================================
// Module   : spi_sclk_tick
// Purpose  : Half-period timer for the SPI master. It counts CLK_DIV cycles
//            and raises tick in the last one. A load restarts the count.
//            With extend set, the load adds one extra cycle to the period.
// Ports    : clk, rst   - system clock, synchronous active-high reset
//            load       - restart the period (used on every state change)
//            extend     - with load: next period lasts CLK_DIV+1 cycles
//            tick       - high in the final cycle of the current period
// Revision : 1.0 - initial release
// ============================================================================
module spi_sclk_tick #(
  parameter int CLK_DIV = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic extend,
  output logic tick
);

  localparam int CNT_W = $clog2(CLK_DIV + 1);
  localparam logic [CNT_W-1:0] RELOAD     = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] RELOAD_EXT = CNT_W'(CLK_DIV);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= RELOAD;
    end else if (load) begin
      cnt <= extend ? RELOAD_EXT : RELOAD;
    end else if (cnt == '0) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign tick = (cnt == '0);

endmodule
`default_nettype wire

// File: rtl/spi_master_mem.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_mem
// Purpose  : SPI mode-0 master, MSB first. It turns one parallel read or
//            write request into a single {rw, addr, data} frame on the
//            cs/sclk/mosi pins. During reads it captures miso.
// Ports    : clk, rst              - system clock, synchronous active-high reset
//            start, rw, addr, wdata - request (accepted only while idle)
//            busy                  - high from accept to the end of the gap
//            done                  - one-cycle pulse when cs returns high
//            rdata                 - last read result, held until next read
//            cs, sclk, mosi, miso  - SPI pins (cs active low, sclk idles low)
// Revision : 1.0 - initial release
// ============================================================================
module spi_master_mem
  import spi_mem_pkg::*;
#(
  parameter int CLK_DIV = 5,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              cs,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso
);

  localparam int FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int BIT_W   = $clog2(FRAME_W + 1);

  spi_m_state_t state, state_next;

  logic [FRAME_W-1:0] frame_in;
  // Holds the bits that still have to go out after the one on mosi now.
  logic [FRAME_W-2:0] shift;
  logic [DATA_W-1:0]  rx;
  logic [BIT_W-1:0]   bit_cnt;   // bits remaining after the current one
  logic               rw_q;
  logic               tick;
  logic               cnt_load;
  logic               cnt_extend;

  assign frame_in = {rw, addr, rw ? wdata : {DATA_W{1'b0}}};

  spi_sclk_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .load   (cnt_load),
    .extend (cnt_extend),
    .tick   (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = LOW;
      LOW:     if (tick)  state_next = HIGH;
      HIGH:    if (tick)  state_next = (bit_cnt == '0) ? HOLD : LOW;
      HOLD:    if (tick)  state_next = GAP;
      GAP:     if (tick)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // The counter is held loaded while idle. This way the first LOW phase
    // gets a full half-period. The gap gets one extra cycle, so busy drops
    // one cycle after the last cs-high period of CLK_DIV cycles has ended.
    cnt_load   = (state_next != state) || (state == IDLE);
    cnt_extend = (state_next == GAP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cs      <= 1'b1;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rdata   <= '0;
      shift   <= '0;
      rx      <= '0;
      bit_cnt <= '0;
      rw_q    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            shift   <= frame_in[FRAME_W-2:0];
            mosi    <= frame_in[FRAME_W-1];
            rw_q    <= rw;
            bit_cnt <= BIT_W'(FRAME_W - 1);
            cs      <= 1'b0;
            busy    <= 1'b1;
          end
        end
        LOW: begin
          if (tick) begin
            sclk <= 1'b1;
            // Mode 0: the slave's bit is sampled at the same edge as sclk rises.
            rx   <= {rx[DATA_W-2:0], miso};
          end
        end
        HIGH: begin
          if (tick) begin
            sclk <= 1'b0;
            if (bit_cnt != '0) begin
              bit_cnt <= bit_cnt - BIT_W'(1);
              mosi    <= shift[FRAME_W-2];
              shift   <= {shift[FRAME_W-3:0], 1'b0};
            end
          end
        end
        HOLD: begin
          if (tick) begin
            cs   <= 1'b1;
            mosi <= 1'b0;
            done <= 1'b1;
            if (!rw_q) begin
              rdata <= rx;
            end
          end
        end
        GAP: begin
          if (tick) begin
            busy <= 1'b0;
          end
        end
        default: begin
          cs   <= 1'b1;
          sclk <= 1'b0;
          mosi <= 1'b0;
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
